// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode legality helper for the
// sequential N-bit ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_MUL: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_nbit_if.sv
// Request/result bundle between the register-read stage (master) and the
// sequential ALU (slave).
interface alu_seq_nbit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             illegal;

  modport master (
    output start, alu_ctrl, src_a, src_b,
    input  ready, busy, done, result, result_hi,
           zero, overflow, carry_out, illegal
  );

  modport slave (
    input  start, alu_ctrl, src_a, src_b,
    output ready, busy, done, result, result_hi,
           zero, overflow, carry_out, illegal
  );
endinterface

// File: rtl/alu_nbit_comb.sv
// Combinational N-bit ALU slice: shared adder/subtractor with signed
// overflow and set-less-than, plus the bitwise operations.
module alu_nbit_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       ctrl_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic             sub;
  logic             arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic             carry_into_msb;
  logic             ovf;
  logic             set;

  // Subtraction is a + ~b + 1 through the same adder.
  assign sub      = (ctrl_i == ALU_SUB) || (ctrl_i == ALU_SLT);
  assign arith    = sub || (ctrl_i == ALU_ADD);
  assign b_eff    = sub ? ~b_i : b_i;
  assign sum_full = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign sum_o    = sum_full[WIDTH-1:0];

  // Carry into the MSB recovered from the MSB sum bit and its inputs.
  assign carry_into_msb = a_i[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_full[WIDTH-1];
  assign ovf            = carry_into_msb ^ sum_full[WIDTH];
  assign set            = sum_full[WIDTH-1] ^ ovf;

  assign carry_o    = arith & sum_full[WIDTH];
  assign overflow_o = arith & ovf;

  // Result select; illegal opcodes (and MUL, handled elsewhere) give zero.
  always_comb begin
    // NOTE: result_o gets a default before the case so no path leaves it unassigned (no latch).
    result_o = '0;
    case (ctrl_i)
      ALU_AND:          result_o = a_i & b_i;
      ALU_OR:           result_o = a_i | b_i;
      ALU_NOR:          result_o = ~(a_i | b_i);
      ALU_ADD, ALU_SUB: result_o = sum_full[WIDTH-1:0];
      ALU_SLT:          result_o = {{(WIDTH-1){1'b0}}, set};
      default:          result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU: single-cycle logic/arithmetic ops and a WIDTH-cycle
// unsigned shift-add multiply, behind a start/ready handshake.
// Handshake flags are written inside each state's branch, so every flag
// appears one cycle after its state: done pulses the cycle after DONE, and
// ready rises one cycle after that.
module alu_seq_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_nbit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q, result_hi_q;
  logic             zero_q, ovf_q, carry_q, ill_q;
  logic             ready_q, busy_q, done_q;

  logic [WIDTH-1:0] comb_a, comb_b, comb_sum, comb_result;
  logic [3:0]       comb_op;
  logic             comb_carry, comb_ovf;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;

  // During MUL the adder adds the multiplicand (or 0) into the upper accumulator.
  always_comb begin
    comb_a  = a_q;
    comb_b  = b_q;
    comb_op = op_q;
    if (state_q == MUL) begin
      comb_a  = hi_q;
      comb_b  = lo_q[0] ? a_q : '0;
      comb_op = ALU_ADD;
    end
  end

  alu_nbit_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i        (comb_a),
    .b_i        (comb_b),
    .ctrl_i     (comb_op),
    .sum_o      (comb_sum),
    .result_o   (comb_result),
    .carry_o    (comb_carry),
    .overflow_o (comb_ovf)
  );

  // One shift-add step: {carry, sum, lo} shifted right by one.
  assign mul_hi_d = {comb_carry, comb_sum[WIDTH-1:1]};
  assign mul_lo_d = {comb_sum[0], lo_q[WIDTH-1:1]};

  // Control FSM with registered datapath and handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= ALU_AND;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      carry_q     <= 1'b0;
      ill_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && ready_q) begin
            op_q    <= bus.alu_ctrl;
            a_q     <= bus.src_a;
            b_q     <= bus.src_b;
            hi_q    <= '0;
            lo_q    <= bus.src_b;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (bus.alu_ctrl == ALU_MUL) ? MUL : EXEC;
          end else begin
            ready_q <= 1'b1;
          end
        end
        EXEC: begin
          result_q    <= comb_result;
          result_hi_q <= '0;
          zero_q      <= (comb_result == '0);
          ovf_q       <= comb_ovf;
          carry_q     <= comb_carry;
          ill_q       <= !is_legal_op(op_q);
          state_q     <= DONE;
        end
        MUL: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            result_q    <= lo_q;
            result_hi_q <= hi_q;
            zero_q      <= (lo_q == '0) && (hi_q == '0);
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            state_q     <= DONE;
          end else begin
            hi_q  <= mul_hi_d;
            lo_q  <= mul_lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = carry_q;
  assign bus.illegal   = ill_q;

endmodule
